seq_div_32: RTL and testbench
=============================

Name: seq_div_32

Overview:
- Multi-cycle restoring integer divider for the datapath ALU.
- Produces quotient and remainder by one trial subtraction per cycle, with a restore (add-back) when the trial result goes negative.
- Complements the combinational ripple adder/subtractor, and reuses that same add/sub structure as its single per-cycle arithmetic unit.
- Supports signed and unsigned operation. Start/done handshake is driven by the ALU control.

Parameters:
- WIDTH, 32: operand, quotient and remainder width in bits.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous reset, active-high.
- START  input  1  request a division; sampled only in IDLE.
- SIGNED  input  1  1 = two's-complement division, 0 = unsigned; latched with START.
- DIVIDEND  input  WIDTH  numerator; latched with START.
- DIVISOR  input  WIDTH  denominator; latched with START.
- BUSY  output  1  high from the cycle after START is accepted until DONE.
- DONE  output  1  one-cycle pulse; results valid from this cycle onward.
- QUOTIENT  output  WIDTH  result quotient; held until the next DONE.
- REMAINDER  output  WIDTH  result remainder; held until the next DONE.
- DIV_BY_ZERO  output  1  set with DONE when the latched DIVISOR was 0; held with the results.

Behaviour:
- Reset (RST=1 at a rising edge):
  - state goes to IDLE and the iteration counter to 0;
  - BUSY=0, DONE=0, QUOTIENT=0, REMAINDER=0, DIV_BY_ZERO=0.
  - Reset overrides START and aborts any division in progress; no DONE is produced for the aborted operation.
- States: IDLE, PREP, ITER, FIX.
- IDLE:
  - START=1 latches SIGNED, DIVIDEND and DIVISOR, then goes to PREP.
  - START=0 stays in IDLE.
- PREP (1 cycle):
  - If SIGNED, take the magnitudes of both operands and record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend).
  - If unsigned, use the operands as-is and clear neg_q and neg_r.
  - Clear the partial remainder and set the counter to WIDTH-1.
  - If the divisor is 0, go straight to FIX with the zero-divide flag set; otherwise go to ITER.
- ITER (WIDTH cycles, one quotient bit per cycle, MSB first):
  - Shift {partial remainder, dividend} left by 1.
  - Compute trial = partial remainder − divisor using a WIDTH+1-bit subtract, so the borrow is visible.
  - If trial is non-negative, partial remainder = trial and the quotient LSB = 1.
  - Otherwise restore: keep the shifted remainder and set the quotient LSB = 0.
  - Counter decrements each cycle; when it reaches 0 after the final bit, go to FIX.
- FIX (1 cycle):
  - QUOTIENT = neg_q ? −q : q.
  - REMAINDER = neg_r ? −r : r.
  - DONE=1 for this one cycle; next state IDLE.
- Divide by zero:
  - QUOTIENT = all ones; REMAINDER = the original DIVIDEND, unmodified; DIV_BY_ZERO=1.
  - DONE arrives 2 cycles after acceptance.
- Latency, with START accepted at edge E0:
  - normal operation: DONE is high during the cycle following edge E0+WIDTH+2;
  - divide by zero: DONE is high during the cycle following edge E0+2.
- BUSY:
  - high in PREP, ITER and FIX;
  - low in IDLE, including the cycle in which DONE is high.
  - Note: DONE is registered in FIX and visible while the state is already IDLE, so BUSY and DONE are never both high.
- START while BUSY=1 is ignored, and the latched operands do not change.
- A new START in the same cycle as DONE is accepted: the results stay valid until the next DONE.
- Signed overflow (−2^(WIDTH−1) / −1): QUOTIENT = 0x80000000 (wraps), REMAINDER = 0, DIV_BY_ZERO=0. No exception is raised.
- Results hold indefinitely in IDLE; DIV_BY_ZERO is cleared at the next DONE if the divisor was non-zero.
- Sign conventions: the quotient truncates toward zero; the remainder takes the sign of the dividend; dividend = Q×divisor + R always holds.

Test Plan:
- Reset during ITER (assert RST 10 cycles after START) -> next cycle BUSY=0 and all outputs 0; no DONE pulse follows; a subsequent 7/2 completes normally.
- Unsigned: DIVIDEND=100, DIVISOR=7, SIGNED=0 -> DONE exactly 34 cycles after acceptance, QUOTIENT=14, REMAINDER=2, DIV_BY_ZERO=0.
- Signed: DIVIDEND=−7 (0xFFFFFFF9), DIVISOR=2, SIGNED=1 -> QUOTIENT=0xFFFFFFFD (−3), REMAINDER=0xFFFFFFFF (−1); and 7/−2 -> QUOTIENT=−3, REMAINDER=1.
- Unsigned big: DIVIDEND=0xFFFFFFFF, DIVISOR=1, SIGNED=0 -> QUOTIENT=0xFFFFFFFF, REMAINDER=0; same operands with SIGNED=1 -> QUOTIENT=0xFFFFFFFF (−1), REMAINDER=0.
- Divide by zero: DIVIDEND=0x12345678, DIVISOR=0 -> DONE 2 cycles after acceptance, QUOTIENT=0xFFFFFFFF, REMAINDER=0x12345678, DIV_BY_ZERO=1.
- Handshake:
  - pulse START again mid-operation with different operands -> ignored; the first result (100/7) is returned;
  - assert START with 9/4 in the DONE cycle -> BUSY rises next cycle, and 34 cycles later QUOTIENT=2, REMAINDER=1;
  - signed 0x80000000 / 0xFFFFFFFF -> QUOTIENT=0x80000000, REMAINDER=0.

Source files
------------

// File: rtl/seq_div_32_if.sv
// seq_div_32_if: start/done handshake and operand/result bus between ALU control and the divider
//   master: ALU control, drives START/SIGNED/DIVIDEND/DIVISOR and reads the results
//   slave : divider, reads operands and drives BUSY/DONE/QUOTIENT/REMAINDER/DIV_BY_ZERO
interface seq_div_32_if #(parameter int WIDTH = 32);
    logic             START;
    logic             SIGNED;
    logic [WIDTH-1:0] DIVIDEND;
    logic [WIDTH-1:0] DIVISOR;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] QUOTIENT;
    logic [WIDTH-1:0] REMAINDER;
    logic             DIV_BY_ZERO;
    modport master (
        output START, SIGNED, DIVIDEND, DIVISOR,
        input  BUSY, DONE, QUOTIENT, REMAINDER, DIV_BY_ZERO
    );
    modport slave (
        input  START, SIGNED, DIVIDEND, DIVISOR,
        output BUSY, DONE, QUOTIENT, REMAINDER, DIV_BY_ZERO
    );
endinterface

// File: rtl/seq_div_32.sv
// seq_div_32: multi-cycle restoring signed/unsigned divider, one quotient bit per cycle
//   CLK, RST : clock, synchronous active-high reset
//   bus      : slave side of seq_div_32_if (START/SIGNED/DIVIDEND/DIVISOR in,
//              BUSY/DONE/QUOTIENT/REMAINDER/DIV_BY_ZERO out)
module seq_div_32 #(parameter int WIDTH = 32) (
    input logic         CLK,
    input logic         RST,
    seq_div_32_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;
    state_t                   state;
    logic                     sg, neg_q, neg_r, dz;
    logic [WIDTH-1:0]         a, b, r;
    logic [$clog2(WIDTH)-1:0] cnt;
    logic [WIDTH:0]           trial;
    // a holds the dividend bits still to be shifted in and, from the low end, the quotient;
    // r < b always holds, so the shifted remainder minus b fits a WIDTH+1-bit signed result
    assign trial = {r, a[WIDTH-1]} - {1'b0, b};
    always_ff @(posedge CLK) begin
        if (RST) begin
            state           <= IDLE;
            cnt             <= '0;
            sg              <= 1'b0;
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
            dz              <= 1'b0;
            a               <= '0;
            b               <= '0;
            r               <= '0;
            bus.BUSY        <= 1'b0;
            bus.DONE        <= 1'b0;
            bus.QUOTIENT    <= '0;
            bus.REMAINDER   <= '0;
            bus.DIV_BY_ZERO <= 1'b0;
        end else begin
            bus.DONE <= 1'b0;
            case (state)
                IDLE: if (bus.START) begin
                    sg       <= bus.SIGNED;
                    a        <= bus.DIVIDEND;
                    b        <= bus.DIVISOR;
                    bus.BUSY <= 1'b1;
                    state    <= PREP;
                end
                PREP: begin
                    // on a zero divisor a keeps the raw dividend so it can be returned untouched
                    dz    <= (b == '0);
                    a     <= (sg && a[WIDTH-1] && b != '0) ? -a : a;
                    b     <= (sg && b[WIDTH-1]) ? -b : b;
                    neg_q <= sg & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_r <= sg & a[WIDTH-1];
                    r     <= '0;
                    cnt   <= $bits(cnt)'(WIDTH - 1);
                    state <= (b == '0) ? FIX : ITER;
                end
                ITER: begin
                    r     <= trial[WIDTH] ? {r[WIDTH-2:0], a[WIDTH-1]} : trial[WIDTH-1:0];
                    a     <= {a[WIDTH-2:0], ~trial[WIDTH]};
                    cnt   <= cnt - 1'b1;
                    state <= (cnt == '0) ? FIX : ITER;
                end
                FIX: begin
                    bus.QUOTIENT    <= dz ? '1 : (neg_q ? -a : a);
                    bus.REMAINDER   <= dz ? a : (neg_r ? -r : r);
                    bus.DIV_BY_ZERO <= dz;
                    bus.DONE        <= 1'b1;
                    bus.BUSY        <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_div_32.sv
// tb_seq_div_32: randomized self-checking bench for seq_div_32 against an arithmetic reference model
module tb_seq_div_32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] prev_q = '0;
    logic [31:0] prev_r = '0;
    seq_div_32_if #(.WIDTH(32)) bus();
    seq_div_32 #(.WIDTH(32)) dut (.CLK(clk), .RST(rst), .bus(bus.slave));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // reference: truncating division, remainder follows dividend sign
    task automatic model(input logic sg, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] q, output logic [31:0] rm, output int lat);
        lat = (y == 0) ? 2 : 34;
        if (y == 0) begin
            q = 32'hFFFF_FFFF; rm = x;
        end else if (sg && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; rm = 0;
        end else if (sg) begin
            q = 32'($signed(x) / $signed(y)); rm = 32'($signed(x) % $signed(y));
        end else begin
            q = x / y; rm = x % y;
        end
    endtask

    // called at a negedge; returns at the negedge of the DONE cycle
    task automatic do_div(input logic sg, input logic [31:0] x, input logic [31:0] y, input bit poke);
        logic [31:0] eq, er;
        int lat, n;
        model(sg, x, y, eq, er, lat);
        bus.START = 1'b1; bus.SIGNED = sg; bus.DIVIDEND = x; bus.DIVISOR = y;
        @(posedge clk); #1;
        bus.START = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("busy_rise", 32'(bus.BUSY), 32'd1);
                check("hold_q", bus.QUOTIENT, prev_q);
                check("hold_r", bus.REMAINDER, prev_r);
            end
            if (poke && n == 10) begin
                bus.START = 1'b1; bus.SIGNED = ~sg; bus.DIVIDEND = 32'd5; bus.DIVISOR = 32'd3;
            end
            if (poke && n == 11) bus.START = 1'b0;
        end while (!bus.DONE && n < 100);
        check("latency", 32'(n - 1), 32'(lat));
        check("busy_at_done", 32'(bus.BUSY), 32'd0);
        check("quotient", bus.QUOTIENT, eq);
        check("remainder", bus.REMAINDER, er);
        check("div_by_zero", 32'(bus.DIV_BY_ZERO), 32'(y == 0));
        prev_q = eq; prev_r = er;
    endtask

    initial begin
        logic [31:0] x, y;
        int seen;
        bus.START = 1'b0; bus.SIGNED = 1'b0; bus.DIVIDEND = '0; bus.DIVISOR = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_done", 32'(bus.DONE), 32'd0);
        check("rst_q", bus.QUOTIENT, 32'd0);
        check("rst_r", bus.REMAINDER, 32'd0);
        check("rst_dz", 32'(bus.DIV_BY_ZERO), 32'd0);
        // abort a running division with reset
        bus.START = 1'b1; bus.SIGNED = 1'b0; bus.DIVIDEND = 32'd100; bus.DIVISOR = 32'd7;
        @(negedge clk);
        bus.START = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(bus.BUSY), 32'd0);
        check("abort_q", bus.QUOTIENT, 32'd0);
        check("abort_r", bus.REMAINDER, 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.DONE) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        do_div(1'b0, 32'd7, 32'd2, 1'b0);
        do_div(1'b0, 32'd100, 32'd7, 1'b1);
        do_div(1'b0, 32'd9, 32'd4, 1'b0);
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        do_div(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0);
        do_div(1'b0, 32'h1234_5678, 32'd0, 1'b0);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_div(1'b0, 32'd5, 32'hFFFF_FFFF, 1'b0);
        do_div(1'b1, 32'hFFFF_FFF0, 32'd0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            x = $urandom;
            case ($urandom_range(0, 3))
                0: y = $urandom_range(1, 15);
                1: y = 32'($urandom_range(0, 1)) - 32'd1;
                2: y = $urandom >> $urandom_range(0, 31);
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) y = 0;
            do_div(1'($urandom_range(0, 1)), x, y, 1'($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
